// File: rtl/pushdly_cal.sv
// pushdly_cal: loop-back latency calibrator for the push delay line; measures echo latency and derives DELAY.
// Optional PUSHDLY_CAL_AVG_EN averages four back-to-back passes per START.
module pushdly_cal #(
  parameter int MAXCNT = 63,
  parameter int QUIET  = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [5:0] target,
  input  logic       echo,
  output logic       pulse,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [5:0] meas,
  output logic [4:0] delay
);
  typedef enum logic [2:0] {S_IDLE, S_QUIET, S_FIRE, S_WAIT, S_FINISH} state_t;
  localparam logic [3:0] QLIM = 4'(QUIET);
  localparam logic [5:0] WLIM = 6'(MAXCNT);
  state_t state, state_n;
  logic [3:0] qcnt, qcnt_n;
  logic [5:0] wcnt, wcnt_n;
  logic timeout_n;
  logic [5:0] meas_n;
  logic [4:0] delay_n;
  logic signed [6:0] diff;
`ifdef PUSHDLY_CAL_AVG_EN
  logic [1:0] pass, pass_n;
  logic [7:0] sum, sum_n, rnd;
`endif
  assign diff = $signed({1'b0, target}) - $signed({1'b0, meas});
  always_comb begin
    state_n = state;
    qcnt_n = qcnt;
    wcnt_n = wcnt;
    timeout_n = timeout;
    meas_n = meas;
    delay_n = delay;
`ifdef PUSHDLY_CAL_AVG_EN
    pass_n = pass;
    sum_n = sum;
    rnd = '0;
`endif
    case (state)
      S_IDLE: if (start) begin
        state_n = S_QUIET;
        qcnt_n = '0;
        wcnt_n = '0;
        timeout_n = 1'b0;
`ifdef PUSHDLY_CAL_AVG_EN
        pass_n = '0;
        sum_n = '0;
`endif
      end
      S_QUIET: begin
        qcnt_n = echo ? 4'd0 : qcnt + 4'd1;
        wcnt_n = wcnt + 6'd1;
        if (!echo && qcnt + 4'd1 == QLIM) state_n = S_FIRE;
        else if (wcnt + 6'd1 == WLIM) begin
          timeout_n = 1'b1;
          meas_n = '0;
          state_n = S_FINISH;
        end
      end
      S_FIRE: begin
        wcnt_n = 6'd1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (echo) begin
`ifdef PUSHDLY_CAL_AVG_EN
          sum_n = sum + {2'b00, wcnt};
          rnd = sum_n + 8'd2;
          if (pass == 2'd3) begin
            meas_n = rnd[7:2];
            state_n = S_FINISH;
          end else begin
            pass_n = pass + 2'd1;
            qcnt_n = '0;
            wcnt_n = '0;
            state_n = S_QUIET;
          end
`else
          meas_n = wcnt;
          state_n = S_FINISH;
`endif
        end else if (wcnt == WLIM) begin
          timeout_n = 1'b1;
          meas_n = '0;
          state_n = S_FINISH;
        end else wcnt_n = wcnt + 6'd1;
      end
      S_FINISH: begin
        if (!timeout) delay_n = diff[6] ? 5'd0 : diff > 7'sd31 ? 5'd31 : diff[4:0];
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= S_IDLE;
      qcnt <= '0;
      wcnt <= '0;
      pulse <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      meas <= '0;
      delay <= '0;
`ifdef PUSHDLY_CAL_AVG_EN
      pass <= '0;
      sum <= '0;
`endif
    end else begin
      state <= state_n;
      qcnt <= qcnt_n;
      wcnt <= wcnt_n;
      pulse <= state_n == S_FIRE;
      busy <= state_n != S_IDLE;
      done <= state_n == S_FINISH;
      timeout <= timeout_n;
      meas <= meas_n;
      delay <= delay_n;
`ifdef PUSHDLY_CAL_AVG_EN
      pass <= pass_n;
      sum <= sum_n;
`endif
    end
  end
endmodule

// File: tb/tb_pushdly_cal.sv
// tb_pushdly_cal: scoreboard bench for pushdly_cal with a modelled loop-back path (PULSE delayed N flops).
// Honours PUSHDLY_CAL_AVG_EN by modelling four passes per START.
module tb_pushdly_cal;
  localparam int Q = 4;
  localparam int MX = 63;
`ifdef PUSHDLY_CAL_AVG_EN
  localparam int NPASS = 4;
`else
  localparam int NPASS = 1;
`endif
  typedef struct {
    logic [5:0] meas;
    logic [4:0] delay;
    logic to;
    int lat;
    int np;
  } exp_t;
  logic clk = 1'b0;
  logic rst_b, start, echo, pulse, busy, done, timeout;
  logic [5:0] target, meas;
  logic [4:0] delay;
  logic [79:0] sr = '0;
  int ps = 0;
  int base, mode, idx, dcur;
  int dq[4];
  int n_chk = 0, n_fail = 0;
  logic [4:0] exp_delay = '0;
  exp_t sb[$];

  pushdly_cal #(.MAXCNT(MX), .QUIET(Q)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .target(target), .echo(echo),
    .pulse(pulse), .busy(busy), .done(done), .timeout(timeout), .meas(meas), .delay(delay)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    sr <= {sr[78:0], pulse};
    ps <= ps + int'(pulse);
  end
  always_comb begin
    idx = ps - base - 1;
    if (idx < 0) idx = 0;
    if (idx > 3) idx = 3;
    dcur = dq[idx];
    echo = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : dcur == 0 ? pulse : dcur <= 80 ? sr[dcur-1] : 1'b0;
  end

  function automatic logic [4:0] clamp5(input int v);
    return v < 0 ? 5'd0 : v > 31 ? 5'd31 : 5'(v);
  endfunction

  task automatic drain();
    int c = 0;
    mode = 0;
    while ((sr != '0 || echo) && c < 120) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int m, input int a, input int b, input int c, input int e, input int tgt);
    exp_t x;
    int sum = 0, lat = 2, np = 0, cyc, w = 0;
    bit to = 0, seen = 0;
    dq = '{a, b, c, e};
    for (int i = 0; i < NPASS && !to; i++) begin
      if (m == 2) begin
        lat += MX;
        to = 1;
      end else begin
        np++;
        lat += Q + 1;
        if (m == 1 || dq[i] < 1 || dq[i] > MX) begin
          lat += MX;
          to = 1;
        end else begin
          lat += dq[i];
          sum += dq[i];
        end
      end
    end
    x.to = to;
    x.meas = to ? 6'd0 : NPASS == 4 ? 6'((sum + 2) >> 2) : 6'(sum);
    if (!to) exp_delay = clamp5(tgt - int'(x.meas));
    x.delay = exp_delay;
    x.lat = lat;
    x.np = np;
    sb.push_back(x);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    target = 6'(tgt);
    base = ps;
    cyc = 1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (pulse) w++;
      if (done) seen = 1;
    end
    x = sb.pop_front();
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_seen: no DONE within %0d cycles (tgt %0d dly %0d)", cyc, tgt, a);
    end else begin
      n_chk += 6;
      if (meas !== x.meas) begin n_fail++; $display("FAIL meas: got %0d expected %0d (dly %0d)", meas, x.meas, a); end
      if (timeout !== x.to) begin n_fail++; $display("FAIL timeout: got %0b expected %0b (dly %0d)", timeout, x.to, a); end
      if (cyc != x.lat) begin n_fail++; $display("FAIL latency: got %0d expected %0d (dly %0d)", cyc, x.lat, a); end
      if (ps - base != x.np) begin n_fail++; $display("FAIL pulse_count: got %0d expected %0d", ps - base, x.np); end
      if (w != x.np) begin n_fail++; $display("FAIL pulse_width: got %0d high cycles expected %0d", w, x.np); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_done: got %0b expected 1", busy); end
      @(negedge clk);
      n_chk += 3;
      if (delay !== x.delay) begin n_fail++; $display("FAIL delay: got %0d expected %0d (tgt %0d)", delay, x.delay, tgt); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %0b expected 0", busy); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %0b expected 0", done); end
    end
    drain();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({pulse, busy, done, timeout, meas, delay} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {pulse, busy, done, timeout, meas, delay});
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    run(0, 3, 3, 3, 3, 20);
  endtask

  task automatic test_echo_low();
    run(1, 3, 3, 3, 3, 20);
  endtask

  task automatic test_echo_stuck();
    run(2, 3, 3, 3, 3, 20);
  endtask

  task automatic test_clamp();
    run(0, 40, 40, 40, 40, 10);
    run(0, 1, 1, 1, 1, 50);
  endtask

  task automatic test_boundary();
    run(0, 63, 63, 63, 63, 0);
    run(0, 0, 0, 0, 0, 30);
    run(0, 64, 64, 64, 64, 30);
    run(0, 7, 7, 7, 7, 7);
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    dq = '{10, 10, 10, 10};
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    target = 6'd20;
    base = ps;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0b expected 1", busy); end
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    n_chk++;
    if ({pulse, busy, done, timeout, meas, delay} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %h expected 0", {pulse, busy, done, timeout, meas, delay});
    end
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_chk++;
    if (dn != 0) begin n_fail++; $display("FAIL mid_reset_done: got %0d DONE strobes expected 0", dn); end
    exp_delay = '0;
    drain();
    run(0, 5, 5, 5, 5, 20);
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int got = 0, c = 0;
    dq = '{4, 4, 4, 4};
    mode = 0;
    for (int i = 0; i < 2; i++) begin
      x.meas = 6'd4; x.to = 1'b0; x.delay = 5'd5; x.lat = 0; x.np = NPASS;
      sb.push_back(x);
    end
    exp_delay = 5'd5;
    @(negedge clk);
    start = 1'b1;
    target = 6'd9;
    while (got < 2 && c < 800) begin
      @(negedge clk);
      c++;
      if (done) begin
        got++;
        x = sb.pop_front();
        n_chk += 2;
        if (meas !== x.meas) begin n_fail++; $display("FAIL b2b_meas: got %0d expected %0d", meas, x.meas); end
        if (timeout !== x.to) begin n_fail++; $display("FAIL b2b_timeout: got %0b expected %0b", timeout, x.to); end
        if (got == 1) begin
          @(negedge clk);
          n_chk++;
          if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %0b expected 0", busy); end
          @(negedge clk);
          n_chk++;
          if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_retrigger: got busy %0b expected 1", busy); end
          start = 1'b0;
        end
      end
    end
    n_chk++;
    if (got != 2) begin n_fail++; $display("FAIL b2b_count: got %0d DONE expected 2", got); end
    @(negedge clk);
    n_chk++;
    if (delay !== x.delay) begin n_fail++; $display("FAIL b2b_delay: got %0d expected %0d", delay, x.delay); end
    sb.delete();
    drain();
  endtask

`ifdef PUSHDLY_CAL_AVG_EN
  task automatic test_average();
    run(0, 5, 6, 6, 6, 20);
    run(0, 5, 6, 70, 6, 20);
  endtask
`endif

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    target = '0;
    mode = 0;
    base = 0;
    dq = '{1, 1, 1, 1};
    test_reset();
    test_loopback();
    test_echo_low();
    test_echo_stuck();
    test_clamp();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
`ifdef PUSHDLY_CAL_AVG_EN
    test_average();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pushdly_cal.md
Name: pushdly_cal

Overview:
- Loop-back latency calibrator for the programmable single-bit push delay line.
- Launches a one-clock test pulse, counts clocks until the echo returns, and reports the measured latency.
- Computes the 5-bit DELAY setting that makes the total path equal a requested target.
- Sits beside the delay line in the control FPGA; its outputs are loaded into the delay register by the slow-control logic.

Parameters:
- MAXCNT, 63: wait and quiet watchdog limit in clocks; legal range 2..63.
- QUIET, 4: consecutive ECHO-low clocks required before the pulse is fired; legal range 1..15.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_B  input  1  synchronous reset, active-low.
- START  input  1  request a calibration; sampled only in IDLE.
- TARGET  input  6  requested total latency in clocks.
- ECHO  input  1  returned pulse from the path under test, already synchronous to CLK.
- PULSE  output  1  registered test pulse, one clock wide.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-clock strobe when results are updated.
- TIMEOUT  output  1  sticky error for the last run; cleared by the next accepted START.
- MEAS  output  6  measured latency in clocks; 0 on timeout.
- DELAY  output  5  computed setting, clamp(TARGET - MEAS, 0, 31).

Behaviour:
- Reset: when RST_B=0 at a CLK edge, the block goes to IDLE.
  - PULSE, BUSY, DONE and TIMEOUT go to 0.
  - MEAS and DELAY go to 0.
  - All counters clear.
  - Reset asserted mid-run aborts the run with no DONE.
- States: IDLE, QUIET, FIRE, WAIT, FINISH. All outputs are registered.
- IDLE:
  - START=1 goes to QUIET, clears TIMEOUT, and clears qcnt and wcnt.
  - START in any other state is ignored.
- QUIET:
  - Each clock with ECHO=0 increments qcnt; ECHO=1 resets qcnt to 0.
  - wcnt increments every clock.
  - When qcnt reaches QUIET, go to FIRE.
  - If wcnt reaches MAXCNT first (echo stuck high), set TIMEOUT=1 and MEAS=0, then go to FINISH.
- FIRE:
  - PULSE=1 for exactly this one cycle; wcnt is loaded to 1.
  - Next state is WAIT.
- WAIT:
  - wcnt=1 on the first WAIT cycle and increments each clock.
  - ECHO=1 while wcnt=k sets MEAS=k and goes to FINISH.
  - An echo delayed by N registers after PULSE therefore gives MEAS=N, for N in 1..MAXCNT.
  - Echo coincident with PULSE (N=0) is not seen; the run times out.
  - If wcnt=MAXCNT and ECHO=0, set TIMEOUT=1 and MEAS=0, then go to FINISH.
  - If ECHO=1 on the MAXCNT cycle, the echo wins.
- FINISH:
  - DELAY is updated: TARGET - MEAS, computed in 7-bit signed; below 0 gives 0, above 31 gives 31.
  - On timeout, DELAY holds its previous value.
  - DONE=1 for this cycle, then go to IDLE.
  - MEAS, DELAY and TIMEOUT hold until the next accepted START; MEAS and DELAY change only in FINISH.
- TARGET is sampled in FINISH.
- START held high in IDLE re-triggers on the clock after FINISH; there is no edge detect.
- Latency, run start to DONE: 1 (START) + QUIET + 1 (FIRE) + MEAS + 1 (FINISH) clocks, minimum.

Optional Feature:
- Macro: PUSHDLY_CAL_AVG_EN.
- Defined:
  - Each START performs 4 QUIET/FIRE/WAIT passes back to back, each with a fresh quiet check.
  - The 8-bit sum of the 4 latencies is accumulated.
  - Result: MEAS = (sum + 2) >> 2, rounded half up.
  - A timeout in any pass aborts the remaining passes: TIMEOUT=1, MEAS=0, DONE in FINISH.
  - DELAY uses the averaged MEAS.
- Undefined: a single pass as described above; no accumulator logic is present.

Test Plan:
- Loop-back with ECHO = PULSE through 3 flops, TARGET=20, START pulse -> PULSE high exactly 1 clock, MEAS=3, DELAY=17, DONE 1 clock, TIMEOUT=0, BUSY low after DONE.
- ECHO tied 0, MAXCNT=63 -> TIMEOUT=1, MEAS=0, DELAY unchanged from the prior run (e.g. 17), DONE once, 63 WAIT clocks after FIRE.
- ECHO stuck 1 -> no PULSE, TIMEOUT=1 after 63 QUIET clocks, DONE asserted.
- Clamp checks:
  - Echo delay 40 with TARGET=10 -> MEAS=40, DELAY=0.
  - Echo delay 1 with TARGET=50 -> MEAS=1, DELAY=31.
- RST_B low for 1 clock while in WAIT -> all outputs 0 next cycle, no DONE; a following START produces a correct measurement.
- With PUSHDLY_CAL_AVG_EN defined, echo delays 5, 6, 6, 6 on successive passes -> sum 23, MEAS=6, 4 PULSEs, single DONE.
